// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } dmem_op_t;

  localparam int unsigned DMEM_WORD_BYTES = 4;

endpackage

// File: rtl/dmem_ram_sp.sv
// Single-port word RAM: synchronous read into an output register,
// byte-enabled write. Array contents are never reset.
module dmem_ram_sp
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTH_LOG2-1:0]        addr_i,
  input  logic                         re_i,
  input  logic                         clr_i,
  input  logic                         we_i,
  input  logic [DMEM_WORD_BYTES-1:0]   be_i,
  input  logic [8*DMEM_WORD_BYTES-1:0] wdata_i,
  output logic [8*DMEM_WORD_BYTES-1:0] rdata_o
);

  logic [8*DMEM_WORD_BYTES-1:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [8*DMEM_WORD_BYTES-1:0] rdata_q;

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int unsigned b = 0; b < DMEM_WORD_BYTES; b++) begin
        if (be_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Read register: holds its value until the next read or clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states,
// byte-enabled writes and out-of-range error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic        dmem_re_i,
  input  logic        dmem_we_i,
  input  logic [3:0]  dmem_be_i,
  input  logic [31:0] dmem_wdata_i,
  output logic [31:0] dmem_rdata_i,
  output logic        dmem_ack_o,
  output logic        dmem_err_o
);

  localparam logic [3:0] WCNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  dmem_state_t           state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  dmem_op_t              op_q, op_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic                  req;
  dmem_op_t              in_op;
  logic                  in_err;
  logic [DEPTH_LOG2-1:0] in_idx;
  dmem_op_t              cur_op;
  logic                  cur_err;
  logic [DEPTH_LOG2-1:0] cur_idx;
  logic                  enter_resp;
  logic                  ram_re, ram_clr, ram_we;
  logic                  unused_addr_lsb;

  assign req             = dmem_re_i | dmem_we_i;
  assign in_op           = dmem_re_i ? OP_RD : OP_WR;
  assign in_err          = |dmem_addr[31:DEPTH_LOG2+2];
  assign in_idx          = dmem_addr[DEPTH_LOG2+1:2];
  assign unused_addr_lsb = ^dmem_addr[1:0];

  // With zero wait states the RAM read happens on the sampling edge itself,
  // so the RAM sees the live request in IDLE and the latched one afterwards.
  assign cur_op     = (state_q == IDLE) ? in_op  : op_q;
  assign cur_err    = (state_q == IDLE) ? in_err : err_q;
  assign cur_idx    = (state_q == IDLE) ? in_idx : idx_q;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT:    if (wcnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and wait-counter next values.
  always_comb begin
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (state_q == IDLE && req) begin
      wcnt_d  = WCNT_LOAD;
      idx_d   = in_idx;
      op_d    = in_op;
      be_d    = dmem_be_i;
      wdata_d = dmem_wdata_i;
      err_d   = in_err;
    end else if (state_q == WAIT && wcnt_q != '0) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  // Request latch and wait-counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt_q  <= '0;
      idx_q   <= '0;
      op_q    <= OP_RD;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state only; RAM controls.
  always_comb begin
    dmem_ack_o = (state_q == RESP);
    dmem_err_o = (state_q == RESP) && err_q;
    ram_re     = enter_resp && (cur_op == OP_RD) && !cur_err;
    ram_clr    = enter_resp && cur_err;
    ram_we     = (state_q == RESP) && (op_q == OP_WR) && !err_q;
  end

  dmem_ram_sp #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .addr_i  (cur_idx),
    .re_i    (ram_re),
    .clr_i   (ram_clr),
    .we_i    (ram_we),
    .be_i    (be_q),
    .wdata_i (wdata_q),
    .rdata_o (dmem_rdata_i)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed bench for dmem_responder with wait-state counts 0, 3 and 5.
module tb_dmem_responder;

  localparam int NDUT = 3;
  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam int WS2 = 5;

  logic        clk;
  logic        rst;
  logic [31:0] addr  [NDUT];
  logic        re    [NDUT];
  logic        we    [NDUT];
  logic [3:0]  be    [NDUT];
  logic [31:0] wdata [NDUT];
  logic [31:0] rdata [NDUT];
  logic        ack   [NDUT];
  logic        err   [NDUT];

  int ws_of [NDUT] = '{WS0, WS1, WS2};

  // Reference memory image per instance, word-indexed.
  logic [31:0] mem_m [NDUT][1024];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(
      .DEPTH_LOG2 (10),
      .WAIT_STATES((g == 0) ? WS0 : ((g == 1) ? WS1 : WS2))
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .dmem_addr    (addr[g]),
      .dmem_re_i    (re[g]),
      .dmem_we_i    (we[g]),
      .dmem_be_i    (be[g]),
      .dmem_wdata_i (wdata[g]),
      .dmem_rdata_i (rdata[g]),
      .dmem_ack_o   (ack[g]),
      .dmem_err_o   (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance k; checks latency, ack/err and read data
  // against the model, and updates the model for writes.
  task automatic txn(input int k, input logic [31:0] a, input logic r, input logic w,
                     input logic [3:0] b, input logic [31:0] d,
                     input bit perturb, input logic [31:0] alt,
                     output logic [31:0] got);
    int          n;
    logic        oor;
    logic [9:0]  idx;
    logic [31:0] word;
    oor = |a[31:12];
    idx = a[11:2];
    @(negedge clk);
    addr[k] = a; re[k] = r; we[k] = w; be[k] = b; wdata[k] = d;
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (perturb && n == 1) begin
        addr[k] = alt; wdata[k] = ~d; be[k] = ~b;
      end
    end while (!ack[k] && n < 40);
    got = rdata[k];
    chk("latency", 32'(n), 32'(ws_of[k] + 1));
    chk("ack", {31'b0, ack[k]}, 32'd1);
    chk("err", {31'b0, err[k]}, {31'b0, oor});
    if (r) begin
      chk("rdata", got, oor ? 32'h0 : mem_m[k][idx]);
    end else if (!oor) begin
      word = mem_m[k][idx];
      for (int i = 0; i < 4; i++) if (b[i]) word[8*i +: 8] = d[8*i +: 8];
      mem_m[k][idx] = word;
    end
    re[k] = 1'b0; we[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("ack_pulse", {31'b0, ack[k]}, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] a, d;
    logic        r, w;
    logic [3:0]  b;

    rst = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      addr[k] = '0; re[k] = 1'b0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_rdata", rdata[k], 32'h0);
      chk("rst_ack", {31'b0, ack[k]}, 32'd0);
      chk("rst_err", {31'b0, err[k]}, 32'd0);
    end
    rst = 1'b1;

    // Basic write/read, zero wait states.
    txn(0, 32'h10, 1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, '0, got);
    txn(0, 32'h10, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    chk("basic_rd", got, 32'hDEADBEEF);

    // Byte enables.
    txn(0, 32'h20, 1'b0, 1'b1, 4'hF, 32'h11223344, 1'b0, '0, got);
    txn(0, 32'h20, 1'b0, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, '0, got);
    txn(0, 32'h20, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    chk("be_merge", got, 32'h11BB33DD);

    // Out of range: no aliasing onto word 0.
    txn(0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h13572468, 1'b0, '0, got);
    txn(0, 32'h1000, 1'b0, 1'b1, 4'hF, 32'hFFFFFFFF, 1'b0, '0, got);
    txn(0, 32'h1000, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    chk("oor_rdata", got, 32'h0);
    txn(0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    chk("oor_word0", got, 32'h13572468);

    // Simultaneous read and write is a read only.
    txn(0, 32'h30, 1'b0, 1'b1, 4'hF, 32'h5, 1'b0, '0, got);
    txn(0, 32'h30, 1'b1, 1'b1, 4'hF, 32'hCAFEBABE, 1'b0, '0, got);
    chk("rw_rd", got, 32'h5);
    txn(0, 32'h30, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    chk("rw_keep", got, 32'h5);

    // Three wait states; address changed mid-wait is ignored.
    txn(1, 32'h0, 1'b0, 1'b1, 4'hF, 32'h01234567, 1'b0, '0, got);
    txn(1, 32'h4, 1'b0, 1'b1, 4'hF, 32'h89ABCDEF, 1'b0, '0, got);
    txn(1, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1, 32'h4, got);
    chk("ws3_rd", got, 32'h01234567);
    txn(1, 32'h4, 1'b0, 1'b1, 4'h3, 32'h0000FFFF, 1'b1, 32'h0, got);
    txn(1, 32'h4, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    chk("ws3_wr", got, 32'h89ABFFFF);

    // Randomized traffic on every instance over a small window plus out-of-range hits.
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < 16; i++) begin
        txn(k, 32'h100 + 32'(4 * i), 1'b0, 1'b1, 4'hF, $urandom, 1'b0, '0, got);
      end
      for (int i = 0; i < 24; i++) begin
        a = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
        case ($urandom_range(0, 2))
          0:       begin r = 1'b1; w = 1'b0; end
          1:       begin r = 1'b0; w = 1'b1; end
          default: begin r = 1'b1; w = 1'b1; end
        endcase
        b = 4'($urandom);
        d = $urandom;
        txn(k, a, r, w, b, d, 1'b0, '0, got);
      end
    end

    // Reset during the wait phase of a write aborts it.
    txn(2, 32'h40, 1'b0, 1'b1, 4'hF, 32'h0, 1'b0, '0, got);
    txn(2, 32'h100, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    @(negedge clk);
    addr[2] = 32'h40; re[2] = 1'b0; we[2] = 1'b1; be[2] = 4'hF; wdata[2] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("arst_rdata", rdata[k], 32'h0);
      chk("arst_ack", {31'b0, ack[k]}, 32'd0);
      chk("arst_err", {31'b0, err[k]}, 32'd0);
    end
    we[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_noack", {31'b0, ack[2]}, 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_noack", {31'b0, ack[2]}, 32'd0);
    end
    txn(2, 32'h40, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0, '0, got);
    chk("arst_nowrite", got, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Synthesizable data-memory responder for the `or1200_cpu` data port. It replaces the behavioural data-memory model in system-level simulation and on FPGA. It serves single-outstanding read/write requests from the core's `dmem_*` interface with a configurable wait-state count, byte-enabled writes, registered read data, and an out-of-range error flag. It sits between the CPU data port and a word-organised on-chip RAM.

## Interface
- `DEPTH_LOG2`, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KB)
- `WAIT_STATES`, 0, extra cycles inserted before each acknowledge; legal range 0..15
- `clk`  input  1  single clock, all state on rising edge
- `rst`  input  1  asynchronous, active-low reset
- `dmem_addr`  input  32  byte address; bits [DEPTH_LOG2+1:2] index the word, bits [1:0] ignored
- `dmem_re_i`  input  1  read request
- `dmem_we_i`  input  1  write request
- `dmem_be_i`  input  4  write byte enables; bit n selects wdata[8n+7:8n]
- `dmem_wdata_i`  input  32  write data
- `dmem_rdata_i`  output  32  read data, valid in the `dmem_ack_o` cycle of a read
- `dmem_ack_o`  output  1  one-cycle completion pulse
- `dmem_err_o`  output  1  one-cycle pulse, coincident with ack, for out-of-range address

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on `re|we` high, latch addr, op, be and wdata, and compute range error.
  - Out-of-range means any of addr[31:DEPTH_LOG2+2] is nonzero.
  - If WAIT_STATES=0, go to RESP; otherwise load `wcnt`=WAIT_STATES-1 and go to WAIT.
- WAIT: decrement `wcnt`; go to RESP when `wcnt`==0.
- RESP: perform the access and assert ack for exactly one cycle, then return to IDLE.
  - Read: `dmem_rdata_i` is loaded from RAM at the entry edge into RESP.
  - Write: RAM is updated on the RESP edge for enabled bytes only.
  - Error: no RAM write occurs; `dmem_rdata_i` is 0; err=1 with ack.
- `re` and `we` both high: treated as a read, and no write occurs.
- `be`=0 write: acknowledged, RAM unchanged.
- Initiator holds request signals stable until ack. The responder uses only the values latched in IDLE, so later changes are ignored.
- Requests arriving in WAIT or RESP are not queued. A request still high in IDLE after ack starts a new transaction.
- `dmem_rdata_i` holds its last read value between reads and is not cleared by writes.
- RAM contents are not reset and are undefined until written.

## Timing
- Reset (rst=0, asynchronous): state=IDLE, wcnt=0, `dmem_rdata_i`=0, `dmem_ack_o`=0, `dmem_err_o`=0.
- Reset asserted mid-transaction aborts it: no ack is produced and a pending write is not performed.
- Latency from the request-sampling edge to the ack cycle is 1+WAIT_STATES cycles.
  - WAIT_STATES=0 gives single-cycle memory behaviour.
- Throughput: one transaction per 2+WAIT_STATES cycles; the return through IDLE costs one cycle.
- ack and err are registered outputs, with no combinational path from inputs.
- Address wrap: not performed. Out-of-range accesses error; they do not alias.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, WAIT, RESP}
  - op enum {OP_RD, OP_WR}
  - constant `DMEM_WORD_BYTES`=4
- Sub-module `dmem_ram_sp`: single-port, synchronous-read, byte-enable-write RAM, parameterised by DEPTH_LOG2. It infers block RAM.
- The FSM, request latch and wait counter live in `dmem_responder`.

## Test plan
- Reset, WAIT_STATES=0:
  - Stimulus: write addr 0x10, be=0xF, data 0xDEADBEEF; then read 0x10.
  - Required: ack 1 cycle after each request; rdata=0xDEADBEEF, err=0.
- Byte enables:
  - Stimulus: write 0x11223344 to 0x20 with be=0xF, then write 0xAABBCCDD with be=0x5, then read 0x20.
  - Required: rdata=0x11BB33DD.
- WAIT_STATES=3:
  - Stimulus: read from 0x0.
  - Required: ack exactly 4 cycles after the sampling edge; a changed addr during WAIT has no effect.
- Out of range, DEPTH_LOG2=10:
  - Stimulus: write 0x1000 with data 0xFFFFFFFF, then read 0x1000.
  - Required: ack=1, err=1 on both; rdata=0; word 0 unchanged.
- Simultaneous `re` and `we` at 0x30, with prior content 0x5:
  - Required: read returns 0x5; RAM still holds 0x5.
- Reset mid-transaction:
  - Stimulus: WAIT_STATES=5; assert rst during WAIT of a write to 0x40 (prior 0x0).
  - Required: all outputs 0 immediately, no ack; a subsequent read returns 0x0.
